// File: rtl/n64_joybus_pkg.sv
// Shared Joybus constants, command codes and receiver state encoding.
package n64_joybus_pkg;

    localparam int DEF_LEVEL_WIDTH = 2;
    localparam int DEF_BIT_WIDTH   = 4 * DEF_LEVEL_WIDTH;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [8:0] LEN_SHORT = 9'd8;
    localparam logic [8:0] LEN_READ  = 9'd24;
    localparam logic [8:0] LEN_WRITE = 9'd280;

    localparam logic [7:0] CRC_POLY = 8'h85;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEAS_LOW,
        ST_MEAS_HIGH,
        ST_CHECK,
        ST_WAIT_TX,
        ST_ERROR
    } rx_state_e;

    function automatic logic [8:0] exp_len(input logic [7:0] c);
        logic [8:0] len;
        case (c)
            CMD_READ:                        len = LEN_READ;
            CMD_WRITE:                       len = LEN_WRITE;
            CMD_INFO, CMD_STATUS, CMD_RESET: len = LEN_SHORT;
            default:                         len = LEN_SHORT;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/generate_crc.sv
// Serial CRC-8, message bit shifted into the LSB; caller appends the flush.
module generate_crc
    import n64_joybus_pkg::*;
#(
    parameter logic [7:0] POLY     = CRC_POLY,
    parameter logic [7:0] RESET_TO = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic       data_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= RESET_TO;
        end else if (enable_i) begin
            if (clear_i) begin
                crc_q <= RESET_TO;
            end else if (shift_i) begin
                crc_q <= {crc_q[6:0], data_i} ^ (crc_q[7] ? POLY : 8'h00);
            end
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/joybus_bit_decoder.sv
// Line synchroniser plus low/high run counters; turns pulse widths into bits.
module joybus_bit_decoder
    import n64_joybus_pkg::*;
#(
    parameter int LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int IDLE_SAMPLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic bit_valid_o,
    output logic bit_value_o,
    output logic line_fall_o,
    output logic frame_end_o,
    output logic low_timeout_o
);

    localparam int LW = $clog2(BIT_WIDTH + 1);
    localparam int HW = $clog2(IDLE_SAMPLES + 1);
    localparam logic [LW-1:0] LOW_MAX  = LW'(BIT_WIDTH);
    localparam logic [LW-1:0] LOW_LAST = LW'(BIT_WIDTH - 1);
    localparam logic [LW-1:0] LOW_ONE  = LW'(2 * LEVEL_WIDTH);
    localparam logic [HW-1:0] HIGH_MAX  = HW'(IDLE_SAMPLES);
    localparam logic [HW-1:0] HIGH_LAST = HW'(IDLE_SAMPLES - 1);

    logic          meta_q, s_rx_q;
    logic [LW-1:0] low_q, low_d;
    logic [HW-1:0] high_q, high_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            s_rx_q <= 1'b1;
            low_q  <= '0;
            high_q <= '0;
        end else begin
            meta_q <= data_i;
            s_rx_q <= meta_q;
            low_q  <= low_d;
            high_q <= high_d;
        end
    end

    // Run counters hold the length of the level that just ended.
    always_comb begin
        low_d  = '0;
        high_d = '0;
        if (s_rx_q) begin
            high_d = (high_q == HIGH_MAX) ? high_q : high_q + HW'(1);
        end else begin
            low_d = (low_q == LOW_MAX) ? low_q : low_q + LW'(1);
        end
    end

    assign bit_valid_o   = s_rx_q && (low_q != '0);
    assign bit_value_o   = (low_q < LOW_ONE);
    assign line_fall_o   = !s_rx_q && (high_q != '0);
    assign frame_end_o   = s_rx_q && (high_q >= HIGH_LAST);
    assign low_timeout_o = !s_rx_q && (low_q >= LOW_LAST);

endmodule

// File: rtl/n64_controller_rx.sv
// Joybus console-to-controller frame receiver with tx handoff.
module n64_controller_rx
    import n64_joybus_pkg::*;
#(
    parameter int LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
    parameter int BIT_WIDTH    = 4 * LEVEL_WIDTH,
    parameter int IDLE_SAMPLES = 16,
    parameter int MAX_BITS     = 281
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        data_rx,
    input  logic        tx_handoff,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic [7:0]  data_crc,
    output logic [8:0]  bit_cnt,
    output logic        rx_handoff,
    output logic        frame_err
);

    localparam logic [8:0] BITS_MAX = 9'(MAX_BITS);

    rx_state_e   state_q, state_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d;
    logic [15:0] addr_sh_q, addr_sh_d;
    logic [8:0]  rx_bits_q, rx_bits_d;
    logic        last_q, last_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  crc_q, crc_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        hand_q, hand_d;
    logic        ferr_q, ferr_d;
    logic        tx_seen_q;

    logic       bit_valid, bit_value, line_fall, frame_end, low_timeout;
    logic       clr, crc_shift;
    logic [7:0] crc_val;
    logic [8:0] data_len;

    joybus_bit_decoder #(
        .LEVEL_WIDTH  (LEVEL_WIDTH),
        .BIT_WIDTH    (BIT_WIDTH),
        .IDLE_SAMPLES (IDLE_SAMPLES)
    ) u_dec (
        .clk_i         (sample_clk),
        .rst_ni        (reset_n),
        .data_i        (data_rx),
        .bit_valid_o   (bit_valid),
        .bit_value_o   (bit_value),
        .line_fall_o   (line_fall),
        .frame_end_o   (frame_end),
        .low_timeout_o (low_timeout)
    );

    generate_crc #(
        .POLY     (CRC_POLY),
        .RESET_TO (8'h00)
    ) u_crc (
        .clk_i    (sample_clk),
        .rst_ni   (reset_n),
        .enable_i (1'b1),
        .clear_i  (clr),
        .shift_i  (crc_shift),
        .data_i   (bit_value),
        .crc_o    (crc_val)
    );

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cmd_sh_q  <= '0;
            addr_sh_q <= '0;
            rx_bits_q <= '0;
            last_q    <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            hand_q    <= 1'b0;
            ferr_q    <= 1'b0;
            tx_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_sh_q  <= cmd_sh_d;
            addr_sh_q <= addr_sh_d;
            rx_bits_q <= rx_bits_d;
            last_q    <= last_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            hand_q    <= hand_d;
            ferr_q    <= ferr_d;
            tx_seen_q <= tx_handoff;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_sh_d  = cmd_sh_q;
        addr_sh_d = addr_sh_q;
        rx_bits_d = rx_bits_q;
        last_d    = last_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        hand_d    = hand_q;
        clr       = 1'b0;
        crc_shift = 1'b0;
        data_len  = rx_bits_q - 9'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (line_fall) state_d = ST_MEAS_LOW;
            end
            ST_MEAS_LOW: begin
                if (bit_valid) begin
                    if (rx_bits_q == BITS_MAX) begin
                        state_d = ST_ERROR;
                    end else begin
                        rx_bits_d = rx_bits_q + 9'd1;
                        last_d    = bit_value;
                        state_d   = ST_MEAS_HIGH;
                        if (rx_bits_q < LEN_SHORT) begin
                            cmd_sh_d = {cmd_sh_q[6:0], bit_value};
                        end else if (rx_bits_q < LEN_READ) begin
                            addr_sh_d = {addr_sh_q[14:0], bit_value};
                        end else if (rx_bits_q < LEN_WRITE) begin
                            crc_shift = 1'b1;
                        end
                    end
                end else if (low_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_MEAS_HIGH: begin
                if (line_fall) begin
                    state_d = ST_MEAS_LOW;
                end else if (frame_end) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (last_q && data_len == exp_len(cmd_sh_q)) begin
                    cmd_d   = cmd_sh_q;
                    addr_d  = addr_sh_q;
                    crc_d   = crc_val;
                    cnt_d   = data_len;
                    hand_d  = !hand_q;
                    state_d = ST_WAIT_TX;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_TX: begin
                // The transmitter owns the line here; only its handoff matters.
                if (tx_handoff != tx_seen_q) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                clr = 1'b1;
                if (frame_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            cmd_sh_d  = '0;
            addr_sh_d = '0;
            rx_bits_d = '0;
            last_d    = 1'b0;
        end
        ferr_d = (state_d == ST_ERROR) && (state_q != ST_ERROR);
    end

    assign cmd        = cmd_q;
    assign addr       = addr_q;
    assign data_crc   = crc_q;
    assign bit_cnt    = cnt_q;
    assign rx_handoff = hand_q;
    assign frame_err  = ferr_q;

endmodule
